// File: rtl/serial_dac_mux_if.sv
// rtl/serial_dac_mux_if.sv - write port and DAC pin bundle for serial_dac_mux
// DA_READBACK_EN adds rd_data/rd_valid to the bundle.
interface serial_dac_mux_if #(
  parameter int DATA_W = 10,
  parameter int PAD_W  = 2,
  parameter int CH_NUM = 2
);
  localparam int CH_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int FRAME_W = DATA_W + PAD_W;

  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [DATA_W-1:0] wr_data;
  logic              DA_CLK;
  logic              DA_DIN;
  logic [CH_NUM-1:0] DA_CS;
  logic              DA_DOUT;
  logic [CH_NUM-1:0] pending;
  logic              busy;
  logic              done;
  logic [CH_W-1:0]   done_ch;
`ifdef DA_READBACK_EN
  logic [FRAME_W-1:0] rd_data;
  logic               rd_valid;

  modport slave (
    input  wr_en, wr_ch, wr_data, DA_DOUT,
    output DA_CLK, DA_DIN, DA_CS, pending, busy, done, done_ch, rd_data, rd_valid
  );
  modport master (
    output wr_en, wr_ch, wr_data, DA_DOUT,
    input  DA_CLK, DA_DIN, DA_CS, pending, busy, done, done_ch, rd_data, rd_valid
  );
`else
  modport slave (
    input  wr_en, wr_ch, wr_data, DA_DOUT,
    output DA_CLK, DA_DIN, DA_CS, pending, busy, done, done_ch
  );
  modport master (
    output wr_en, wr_ch, wr_data, DA_DOUT,
    input  DA_CLK, DA_DIN, DA_CS, pending, busy, done, done_ch
  );
`endif
endinterface

// File: rtl/serial_dac_mux.sv
// rtl/serial_dac_mux.sv - multi-channel TLC5615-class serial DAC driver, round-robin
// Optional DA_READBACK_EN: captures DA_DOUT on DA_CLK rises into rd_data.
module serial_dac_mux #(
  parameter int DATA_W   = 10,
  parameter int PAD_W    = 2,
  parameter int CH_NUM   = 2,
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 3
) (
  input  logic              CLK_50M,
  input  logic              RST,
  serial_dac_mux_if.slave   bus
);
  localparam int CH_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int FRAME_W = DATA_W + PAD_W;
  localparam int BC_W    = $clog2(FRAME_W + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t             state;
  logic [DATA_W-1:0]  holding [CH_NUM];
  logic [FRAME_W-1:0] shift_reg;
  logic [CH_W-1:0]    ptr;
  logic [CH_W-1:0]    cur_ch;
  logic [15:0]        cnt;
  logic [BC_W-1:0]    bit_cnt;
  logic               sel_valid;
  logic [CH_W-1:0]    sel_ch;
  int                 idx;
`ifdef DA_READBACK_EN
  logic [FRAME_W-1:0] rd_shift;
`endif

  // Walk downward so the lowest offset from ptr is the one left standing.
  always_comb begin
    sel_valid = 1'b0;
    sel_ch    = '0;
    idx       = 0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % CH_NUM;
      if (bus.pending[idx]) begin
        sel_valid = 1'b1;
        sel_ch    = CH_W'(idx);
      end
    end
  end

  assign bus.busy = (state != IDLE);

  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      for (int i = 0; i < CH_NUM; i++) holding[i] <= '0;
      shift_reg   <= '0;
      ptr         <= '0;
      cur_ch      <= '0;
      cnt         <= '0;
      bit_cnt     <= '0;
      bus.DA_CS   <= '1;
      bus.DA_CLK  <= 1'b0;
      bus.DA_DIN  <= 1'b0;
      bus.pending <= '0;
      bus.done    <= 1'b0;
      bus.done_ch <= '0;
`ifdef DA_READBACK_EN
      rd_shift     <= '0;
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
`ifdef DA_READBACK_EN
      bus.rd_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (sel_valid) begin
            shift_reg            <= {holding[sel_ch], {PAD_W{1'b0}}};
            bus.DA_DIN           <= holding[sel_ch][DATA_W-1];
            bus.pending[sel_ch]  <= 1'b0;
            bus.DA_CS[sel_ch]    <= 1'b0;
            cur_ch               <= sel_ch;
            ptr                  <= (sel_ch == CH_W'(CH_NUM - 1)) ? '0 : sel_ch + 1'b1;
            cnt                  <= '0;
            bit_cnt              <= '0;
`ifdef DA_READBACK_EN
            rd_shift             <= '0;
`endif
            state                <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == 16'(CS_SETUP - 1)) begin
            cnt        <= '0;
            bus.DA_CLK <= 1'b1;
`ifdef DA_READBACK_EN
            rd_shift   <= {rd_shift[FRAME_W-2:0], bus.DA_DOUT};
`endif
            state      <= SHIFT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        SHIFT: begin
          if (cnt == 16'(CLK_DIV - 1)) begin
            cnt <= '0;
            if (bus.DA_CLK) begin
              bus.DA_CLK <= 1'b0;
              shift_reg  <= shift_reg << 1;
              bit_cnt    <= bit_cnt + 1'b1;
              bus.DA_DIN <= (bit_cnt == BC_W'(FRAME_W - 1)) ? 1'b0 : shift_reg[FRAME_W-2];
            end else if (bit_cnt == BC_W'(FRAME_W)) begin
              // Final low half-period completes before the hold window starts.
              state <= HOLD;
            end else begin
              bus.DA_CLK <= 1'b1;
`ifdef DA_READBACK_EN
              rd_shift   <= {rd_shift[FRAME_W-2:0], bus.DA_DOUT};
`endif
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        HOLD: begin
          if (cnt == 16'(CS_HOLD - 1)) begin
            cnt         <= '0;
            bus.DA_CS   <= '1;
            bus.done    <= 1'b1;
            bus.done_ch <= cur_ch;
`ifdef DA_READBACK_EN
            bus.rd_data  <= rd_shift;
            bus.rd_valid <= 1'b1;
`endif
            state       <= GAP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        GAP: begin
          // The IDLE load edge itself supplies the last gap cycle.
          if (int'(cnt) + 2 >= CS_GAP) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
      // Placed last so a same-cycle write beats the load's pending clear.
      if (bus.wr_en && (int'(bus.wr_ch) < CH_NUM)) begin
        holding[bus.wr_ch]     <= bus.wr_data;
        bus.pending[bus.wr_ch] <= 1'b1;
      end
    end
  end
endmodule
